// File: rtl/serial_arbiter_pkg.sv
// Shared types and constants for the two-source byte-serial frame arbiter.
package serial_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam int NUM_SRC         = 2;
  localparam int SRC_TRACE       = 0;
  localparam int SRC_HOST        = 1;
  localparam int DEF_FRAME_BYTES = 16;

  localparam logic [7:0] CNT8_MAX = 8'hFF;

  // Event counter that sticks at its maximum instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == CNT8_MAX) ? v : v + 8'd1;
  endfunction

  function automatic logic [NUM_SRC-1:0] src_onehot(input logic src);
    return src ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/serial_arbiter_if.sv
// Source-side and downstream-side handshake bundle of the frame arbiter.
interface serial_arbiter_if;

  logic [1:0] SrcReq;
  logic [1:0] SrcNext;
  logic [1:0] SrcReady;
  logic [7:0] SrcVal0;
  logic [7:0] SrcVal1;
  logic       DataNext;
  logic       DataReady;
  logic [7:0] DataVal;
  logic [1:0] Grant;
  logic [7:0] TimeoutCnt;

  modport master (
    input  SrcReq, SrcReady, SrcVal0, SrcVal1, DataNext,
    output SrcNext, DataReady, DataVal, Grant, TimeoutCnt
  );

  modport slave (
    output SrcReq, SrcReady, SrcVal0, SrcVal1, DataNext,
    input  SrcNext, DataReady, DataVal, Grant, TimeoutCnt
  );

endinterface

// File: rtl/serial_arb_pick.sv
// Combinational weighted picker: source 0 keeps winning contested rounds until
// it has taken WEIGHT0 frames in a row, then source 1 gets one.
module serial_arb_pick
  import serial_arbiter_pkg::*;
#(
  parameter int WEIGHT0 = 2,
  parameter int C0_W    = $clog2(WEIGHT0 + 1)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [C0_W-1:0]    c0,
  output logic               winner,
  output logic               valid
);

  localparam logic [C0_W-1:0] C0_LIMIT = C0_W'(WEIGHT0);

  always_comb begin
    valid  = |req;
    winner = 1'(SRC_TRACE);
    if (req == 2'b10) begin
      winner = 1'(SRC_HOST);
    end else if (req == 2'b11) begin
      winner = (c0 >= C0_LIMIT);
    end
  end

endmodule

// File: rtl/serial_arbiter.sv
// Weighted round-robin arbiter that forwards whole frames from two byte-serial
// sources to one downstream port and abandons a grant if its source goes silent.
module serial_arbiter
  import serial_arbiter_pkg::*;
#(
  parameter int FRAME_BYTES = DEF_FRAME_BYTES,
  parameter int WEIGHT0     = 2,
  parameter int TIMEOUT     = 1024,
  parameter int TMO_W       = 11
) (
  input logic              clk,
  input logic              rst,
  serial_arbiter_if.master bus
);

  localparam int BCNT_W = $clog2(FRAME_BYTES + 1);
  localparam int C0_W   = $clog2(WEIGHT0 + 1);

  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(FRAME_BYTES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [C0_W-1:0]   C0_MAX    = C0_W'(WEIGHT0);

  state_t             state_reg;
  logic [NUM_SRC-1:0] grant_reg;
  logic [BCNT_W-1:0]  bcnt_reg;
  logic [TMO_W-1:0]   tmo_reg;
  logic [C0_W-1:0]    c0_reg;
  logic               data_ready_reg;
  logic [7:0]         data_val_reg;
  logic [7:0]         timeout_cnt_reg;

  logic [7:0]         src_val [NUM_SRC];
  logic [NUM_SRC-1:0] src_next;
  logic               in_grant;
  logic               owner;
  logic               byte_in;
  logic               pick_winner;
  logic               pick_valid;

  assign src_val[SRC_TRACE] = bus.SrcVal0;
  assign src_val[SRC_HOST]  = bus.SrcVal1;

  assign in_grant = (state_reg == ST_GRANT);
  assign owner    = grant_reg[SRC_HOST];
  // Strobes from the source that does not own the grant are masked out here.
  assign byte_in  = |(bus.SrcReady & grant_reg);

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_next
    assign src_next[gi] = bus.DataNext & grant_reg[gi] & in_grant;
  end

  serial_arb_pick #(
    .WEIGHT0 (WEIGHT0),
    .C0_W    (C0_W)
  ) u_pick (
    .req    (bus.SrcReq),
    .c0     (c0_reg),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      grant_reg       <= '0;
      bcnt_reg        <= '0;
      tmo_reg         <= '0;
      c0_reg          <= '0;
      data_ready_reg  <= 1'b0;
      data_val_reg    <= '0;
      timeout_cnt_reg <= '0;
    end else begin
      data_ready_reg <= 1'b0;
      unique case (state_reg)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_reg <= src_onehot(pick_winner);
            bcnt_reg  <= '0;
            tmo_reg   <= '0;
            state_reg <= ST_GRANT;
            if (pick_winner == 1'(SRC_HOST)) begin
              c0_reg <= '0;
            end else if (c0_reg != C0_MAX) begin
              c0_reg <= c0_reg + C0_W'(1);
            end
          end
        end
        ST_GRANT: begin
          // A byte arriving on the expiry cycle still counts and restarts the timer.
          if (byte_in) begin
            data_val_reg   <= src_val[owner];
            data_ready_reg <= 1'b1;
            bcnt_reg       <= bcnt_reg + BCNT_W'(1);
            tmo_reg        <= '0;
            if (bcnt_reg == BCNT_LAST) begin
              state_reg <= ST_RELEASE;
            end
          end else if (tmo_reg == TMO_LAST) begin
            grant_reg       <= '0;
            timeout_cnt_reg <= sat_inc8(timeout_cnt_reg);
            state_reg       <= ST_IDLE;
          end else begin
            tmo_reg <= tmo_reg + TMO_W'(1);
          end
        end
        ST_RELEASE: begin
          grant_reg <= '0;
          state_reg <= ST_IDLE;
        end
        default: begin
          grant_reg <= '0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.SrcNext    = src_next;
  assign bus.DataReady  = data_ready_reg;
  assign bus.DataVal    = data_val_reg;
  assign bus.Grant      = grant_reg;
  assign bus.TimeoutCnt = timeout_cnt_reg;

endmodule

// File: tb/tb_serial_arbiter.sv
// Bench for serial_arbiter: directed scenarios plus random traffic, every cycle
// compared against a frame-level behavioural model.
module tb_serial_arbiter;
  import serial_arbiter_pkg::*;

  localparam int FB    = 16;
  localparam int W0    = 2;
  localparam int TMO   = 32;
  localparam int TMO_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_arbiter_if bus();

  serial_arbiter #(
    .FRAME_BYTES (FB),
    .WEIGHT0     (W0),
    .TIMEOUT     (TMO),
    .TMO_W       (TMO_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Frame-level model: who owns the port, bytes delivered, silent cycles,
  // source-0 streak, pending release, and the registered outputs.
  typedef struct packed {
    bit busy;
    int owner;
    int got;
    int silent;
    int streak;
    bit rel;
    bit rdy;
    int val;
    int tmos;
  } mdl_t;

  mdl_t m = '0;

  function automatic mdl_t mstep(mdl_t s, logic r, logic [1:0] req, logic [1:0] rdy,
                                 logic [7:0] v0, logic [7:0] v1);
    mdl_t n;
    int w;
    n = s;
    if (r) return mdl_t'(0);
    n.rdy = 1'b0;
    if (s.rel) begin
      n.busy = 1'b0;
      n.rel  = 1'b0;
    end else if (!s.busy) begin
      if (req != 2'b00) begin
        if (req == 2'b11) w = (s.streak < W0) ? 0 : 1;
        else              w = req[0] ? 0 : 1;
        n.busy   = 1'b1;
        n.owner  = w;
        n.got    = 0;
        n.silent = 0;
        n.streak = (w == 0) ? ((s.streak + 1 > W0) ? W0 : s.streak + 1) : 0;
      end
    end else if (rdy[s.owner]) begin
      n.val    = (s.owner == 0) ? int'(v0) : int'(v1);
      n.rdy    = 1'b1;
      n.got    = s.got + 1;
      n.silent = 0;
      if (n.got == FB) n.rel = 1'b1;
    end else if (s.silent == TMO - 1) begin
      n.busy = 1'b0;
      n.tmos = (s.tmos == 255) ? 255 : s.tmos + 1;
    end else begin
      n.silent = s.silent + 1;
    end
    return n;
  endfunction

  always @(posedge clk) m <= mstep(m, rst, bus.SrcReq, bus.SrcReady, bus.SrcVal0, bus.SrcVal1);

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int nxt1_hi = 0;
  logic [1:0] seen_next  = 2'b00;
  logic [1:0] prev_grant = 2'b00;
  int seq [2];
  int resp_left [2];
  int resp_pct [2];
  int q_bytes [$];
  int q_bcyc [$];
  int q_grants [$];
  int q_gcyc [$];
  int q_ecyc [$];

  task automatic check(string name, int got, int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // One clock: compare outputs at the falling edge, then drive sources after the rising edge.
  task automatic step();
    logic [1:0] eg, en, rv;
    logic [7:0] vv [2];
    @(negedge clk);
    cyc++;
    eg = m.busy ? ((m.owner == 0) ? 2'b01 : 2'b10) : 2'b00;
    en = (m.busy && !m.rel && bus.DataNext) ? eg : 2'b00;
    n_tests++;
    if (bus.Grant !== eg || bus.SrcNext !== en || bus.DataReady !== m.rdy ||
        bus.DataVal !== 8'(m.val) || bus.TimeoutCnt !== 8'(m.tmos)) begin
      n_fail++;
      $display("FAIL cycle %0d outputs: got grant=%b next=%b rdy=%b val=%h tmo=%0d, want grant=%b next=%b rdy=%b val=%h tmo=%0d",
               cyc, bus.Grant, bus.SrcNext, bus.DataReady, bus.DataVal, bus.TimeoutCnt,
               eg, en, m.rdy, 8'(m.val), m.tmos);
    end
    seen_next = bus.SrcNext;
    if (bus.SrcNext[1]) nxt1_hi++;
    if (bus.DataReady === 1'b1) begin
      q_bytes.push_back(int'(bus.DataVal));
      q_bcyc.push_back(cyc);
    end
    if (bus.Grant != 2'b00 && prev_grant == 2'b00) begin
      q_grants.push_back(bus.Grant[1] ? 1 : 0);
      q_gcyc.push_back(cyc);
    end
    if (bus.Grant == 2'b00 && prev_grant != 2'b00) q_ecyc.push_back(cyc);
    prev_grant = bus.Grant;
    @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      if (seen_next[i] && resp_left[i] != 0 && int'($urandom_range(99)) < resp_pct[i]) begin
        rv[i] = 1'b1;
        vv[i] = 8'((i == 1 ? 'h80 : 'h00) | (seq[i] & 'h7F));
        seq[i]++;
        if (resp_left[i] > 0) resp_left[i]--;
      end else begin
        rv[i] = 1'b0;
        vv[i] = 8'($urandom);
      end
    end
    bus.SrcReady = rv;
    bus.SrcVal0  = vv[0];
    bus.SrcVal1  = vv[1];
  endtask

  task automatic clear_logs();
    q_bytes.delete();
    q_bcyc.delete();
    q_grants.delete();
    q_gcyc.delete();
    q_ecyc.delete();
    nxt1_hi = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.SrcReq = 2'b00;
    step();
    rst = 1'b0;
    seq[0] = 0;
    seq[1] = 0;
  endtask

  task automatic wait_bytes(int n, string name);
    int k = 0;
    while (q_bytes.size() < n && k < 3000) begin step(); k++; end
    if (q_bytes.size() < n) begin
      n_tests++; n_fail++;
      $display("FAIL %s: wait expired with %0d bytes, want %0d", name, q_bytes.size(), n);
    end
  endtask

  task automatic wait_grants(int n, string name);
    int k = 0;
    while (q_grants.size() < n && k < 3000) begin step(); k++; end
    if (q_grants.size() < n) begin
      n_tests++; n_fail++;
      $display("FAIL %s: wait expired with %0d grants, want %0d", name, q_grants.size(), n);
    end
  endtask

  task automatic wait_idle(string name);
    int k = 0;
    int quiet = 0;
    while (quiet < 3 && k < 3000) begin
      step();
      k++;
      if (bus.Grant == 2'b00 && bus.DataReady == 1'b0) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) begin
      n_tests++; n_fail++;
      $display("FAIL %s: arbiter not idle, grant=%b", name, bus.Grant);
    end
  endtask

  int exp_order [6] = '{0, 0, 1, 0, 0, 1};
  int cnt;

  initial begin
    bus.SrcReq   = 2'b00;
    bus.SrcReady = 2'b00;
    bus.SrcVal0  = 8'h00;
    bus.SrcVal1  = 8'h00;
    bus.DataNext = 1'b0;
    seq          = '{0, 0};
    resp_left    = '{-1, -1};
    resp_pct     = '{100, 100};

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("reset_grant", int'(bus.Grant), 0);
    check("reset_ready", int'(bus.DataReady), 0);
    check("reset_tmocnt", int'(bus.TimeoutCnt), 0);

    // Single source 0 frame
    do_reset();
    clear_logs();
    bus.DataNext = 1'b1;
    bus.SrcReq   = 2'b01;
    step();
    check("t1_grant_after_req", int'(bus.Grant), 1);
    bus.SrcReq = 2'b00;
    wait_idle("t1_idle");
    check("t1_byte_count", q_bytes.size(), FB);
    if (q_bytes.size() >= FB) begin
      for (int i = 0; i < FB; i++) check($sformatf("t1_byte%0d", i), q_bytes[i], i);
      if (q_ecyc.size() >= 1) check("t1_release_gap", q_ecyc[0] - q_bcyc[FB-1], 1);
    end
    check("t1_next1_never", nxt1_hi, 0);

    // Weighted round-robin with both requesting
    do_reset();
    clear_logs();
    bus.SrcReq = 2'b11;
    wait_grants(6, "t2_grants");
    bus.SrcReq = 2'b00;
    wait_idle("t2_idle");
    if (q_grants.size() >= 6)
      for (int i = 0; i < 6; i++) check($sformatf("t2_order%0d", i), q_grants[i], exp_order[i]);
    check("t2_byte_count", q_bytes.size(), 6 * FB);

    // Frame atomicity: source 1 arrives mid-frame
    do_reset();
    clear_logs();
    bus.SrcReq = 2'b01;
    wait_bytes(5, "t3_bytes5");
    bus.SrcReq = 2'b10;
    wait_grants(2, "t3_grants");
    bus.SrcReq = 2'b00;
    wait_idle("t3_idle");
    check("t3_byte_count", q_bytes.size(), 2 * FB);
    if (q_grants.size() >= 2 && q_bytes.size() >= FB + 1) begin
      check("t3_first_owner", q_grants[0], 0);
      check("t3_second_owner", q_grants[1], 1);
      cnt = 0;
      for (int i = 0; i < FB; i++) if (q_bytes[i] < 'h80) cnt++;
      check("t3_src0_bytes_first", cnt, FB);
      check("t3_src1_after", int'(q_bytes[FB] >= 'h80), 1);
      check("t3_grant_gap", q_gcyc[1] - q_bcyc[FB-1], 2);
    end

    // Stray strobe and downstream stall
    do_reset();
    clear_logs();
    bus.SrcReq = 2'b01;
    wait_bytes(4, "t5_bytes4");
    bus.SrcReady[1] = 1'b1;
    bus.SrcVal1     = 8'hEE;
    wait_bytes(6, "t5_bytes6");
    bus.DataNext = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("t5_stall_next%0d", i), int'(bus.SrcNext), 0);
    end
    bus.DataNext = 1'b1;
    bus.SrcReq   = 2'b00;
    wait_idle("t5_idle");
    check("t5_byte_count", q_bytes.size(), FB);
    if (q_bytes.size() >= FB)
      for (int i = 0; i < FB; i++) check($sformatf("t5_byte%0d", i), q_bytes[i], i);
    check("t5_no_timeout", int'(bus.TimeoutCnt), 0);

    // Timeout of a stalled source, other source granted next
    do_reset();
    clear_logs();
    resp_left[0] = 3;
    bus.SrcReq = 2'b11;
    wait_grants(1, "t4_grant1");
    bus.SrcReq = 2'b10;
    wait_grants(2, "t4_grants");
    bus.SrcReq = 2'b00;
    wait_idle("t4_idle");
    resp_left[0] = -1;
    check("t4_tmocnt", int'(bus.TimeoutCnt), 1);
    check("t4_model_tmocnt", m.tmos, 1);
    check("t4_byte_count", q_bytes.size(), 3 + FB);
    if (q_grants.size() >= 2 && q_bytes.size() >= 4 && q_ecyc.size() >= 1) begin
      check("t4_second_owner", q_grants[1], 1);
      check("t4_expiry_gap", q_ecyc[0] - q_bcyc[2], TMO);
      check("t4_3_bytes_first", int'(q_bcyc[3] > q_gcyc[1]), 1);
    end

    // Reset mid-frame (TimeoutCnt is 1 and c0 becomes 1 before it)
    clear_logs();
    bus.SrcReq = 2'b01;
    wait_bytes(9, "t6_bytes9");
    rst = 1'b1;
    bus.SrcReq = 2'b00;
    step();
    check("t6_grant", int'(bus.Grant), 0);
    check("t6_ready", int'(bus.DataReady), 0);
    check("t6_tmocnt", int'(bus.TimeoutCnt), 0);
    rst = 1'b0;
    seq[0] = 0;
    seq[1] = 0;
    clear_logs();
    bus.SrcReq = 2'b11;
    wait_grants(2, "t6_grants");
    bus.SrcReq = 2'b00;
    wait_idle("t6_idle");
    if (q_grants.size() >= 2 && q_bytes.size() >= FB + 1) begin
      check("t6_first_owner", q_grants[0], 0);
      check("t6_second_owner", q_grants[1], 0);
      check("t6_first_byte", q_bytes[0], 0);
      check("t6_full_frame", int'(q_bcyc[FB-1] < q_gcyc[1] && q_bcyc[FB] > q_gcyc[1]), 1);
    end

    // Random traffic
    do_reset();
    clear_logs();
    for (int c = 0; c < 4000; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(99) < 10) bus.SrcReq[i] = ~bus.SrcReq[i];
        if ($urandom_range(99) < 1) resp_pct[i] = ($urandom_range(2) == 0) ? 0 : 70 + 30 * int'($urandom_range(1));
        if ($urandom_range(99) < 3) begin
          bus.SrcReady[i] = 1'b1;
          if (i == 0) bus.SrcVal0 = 8'($urandom);
          else        bus.SrcVal1 = 8'($urandom);
        end
      end
      bus.DataNext = ($urandom_range(99) < 80);
      rst = ($urandom_range(999) < 2);
    end
    rst          = 1'b0;
    bus.SrcReq   = 2'b00;
    bus.DataNext = 1'b1;
    resp_pct     = '{100, 100};
    wait_idle("rand_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_arbiter.md
Name: serial_arbiter

Overview:
- Shares the single byte-serial output (UART or other uplink) between two 16-byte frame sources.
  - Source 0: trace frame serialiser.
  - Source 1: host-response/status frame generator.
- Grants whole frames atomically, so frames from the two sources never interleave.
- Arbitration is weighted round-robin.
- A stalled source that stops delivering bytes is abandoned after a timeout.
- Sits between the frame serialisers and the output device handler.

Parameters:
- FRAME_BYTES, 16: bytes per frame; a grant is released after this many bytes are forwarded.
- WEIGHT0, 2: maximum consecutive frames granted to source 0 while source 1 is requesting; must be ≥1.
- TIMEOUT, 1024: maximum cycles in GRANT without a byte before the grant is abandoned; must be ≥2.
- TMO_W, 11: width of the timeout counter; must satisfy 2^TMO_W > TIMEOUT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- SrcReq  in  2  bit i: source i has a complete frame pending; level signal
- SrcNext  out  2  bit i: byte request forwarded to source i; combinational
- SrcReady  in  2  bit i: one-cycle strobe, source i presents a byte on SrcVal0/SrcVal1
- SrcVal0  in  8  byte from source 0
- SrcVal1  in  8  byte from source 1
- DataNext  in  1  downstream requests the next byte
- DataReady  out  1  one-cycle strobe, DataVal is valid
- DataVal  out  8  byte to downstream
- Grant  out  2  one-hot current owner; 00 when no owner
- TimeoutCnt  out  8  number of abandoned grants; saturates at 255

Behaviour:
- Reset: all of the following clear to 0 on the clock edge while rst=1, and rst overrides every other event in that cycle, including mid-frame.
  - state=IDLE
  - Grant, DataReady, DataVal, TimeoutCnt
  - internal byte counter bcnt, timeout counter tmo, consecutive-source-0 counter c0
- SrcNext[i] = DataNext & Grant[i] & (state==GRANT). It is purely combinational; no other path drives SrcNext.
- Every cycle DataReady defaults to 0.
- States:
  - IDLE
    - If SrcReq==00, remain in IDLE.
    - Otherwise select a source:
      - Only one source requesting: that source wins.
      - Both requesting: source 0 wins if c0 < WEIGHT0, else source 1.
    - On the selection edge: Grant<=winner, bcnt<=0, tmo<=0, go to GRANT. Earliest SrcNext is the next cycle.
    - c0 update: +1 (saturating at WEIGHT0) when source 0 wins; cleared to 0 when source 1 wins.
  - GRANT
    - When SrcReady[g] is seen for the granted source g:
      - DataVal<=SrcVal(g), DataReady<=1 (latency: one cycle from SrcReady).
      - bcnt<=bcnt+1, tmo<=0.
      - If this byte makes bcnt reach FRAME_BYTES, go to RELEASE.
    - SrcReady from the non-granted source is ignored: no output, no state change.
    - With no byte this cycle: tmo<=tmo+1.
    - If tmo==TIMEOUT-1 with no byte this cycle: Grant<=00, TimeoutCnt<=sat(+1), go to IDLE.
      - The partial frame is abandoned.
      - The next frame still follows the arbitration rules.
  - RELEASE
    - Grant<=00, go to IDLE. This gives one dead cycle between frames so a source can drop SrcReq.
- Simultaneous events:
  - A byte and timeout expiry in the same cycle: the byte wins and tmo resets.
  - The last byte: DataReady is still issued on the edge that enters RELEASE.
- SrcReq dropping mid-GRANT does not release the grant; only completion or timeout does.
- A source holding SrcReq continuously gets back-to-back frames separated only by the RELEASE and IDLE cycles (3 cycles minimum from last byte to next SrcNext).
- Widths:
  - bcnt is $clog2(FRAME_BYTES+1) bits.
  - c0 is $clog2(WEIGHT0+1) bits.
  - All counters are unsigned with no wrap; TimeoutCnt holds at 255.

Decomposition:
- Shared package holds:
  - state encoding constants (ST_IDLE, ST_GRANT, ST_RELEASE)
  - source index constants (SRC_TRACE=0, SRC_HOST=1)
  - default FRAME_BYTES
- One sub-module is natural: serial_arb_pick, a combinational weighted picker.
  - Inputs: SrcReq and c0.
  - Outputs: winner index and a valid flag.
- Everything else lives in serial_arbiter.

Test Plan:
- Single source, source 0 only:
  - Stimulus: SrcReq=01, DataNext=1; source 0 answers each SrcNext with bytes 0x00..0x0F.
  - Required: Grant=01 one cycle after the request; exactly 16 DataReady strobes carrying 0x00..0x0F in order; Grant=00 in RELEASE; SrcNext[1] never high.
- Weighted round-robin:
  - Stimulus: SrcReq=11 held for 6 frames, WEIGHT0=2.
  - Required: grant order 0,0,1,0,0,1.
- Frame atomicity:
  - Stimulus: source 1 raises SrcReq at byte 5 of a source-0 frame.
  - Required: all 16 source-0 bytes are output first; Grant=10 only after RELEASE and IDLE.
- Timeout:
  - Stimulus: TIMEOUT=8; the granted source sends 3 bytes, then stays silent.
  - Required: exactly 3 DataReady strobes; Grant=00 exactly 8 cycles after the 3rd byte; TimeoutCnt=1; the other pending source is granted next.
- Stray strobe and downstream stall:
  - Stimulus: SrcReady[1] pulses while Grant=01; DataNext is held low for 20 cycles mid-frame (TIMEOUT=1024).
  - Required: no DataReady from the stray strobe; SrcNext=00 during the stall; the frame resumes and completes with 16 bytes.
- Reset mid-frame:
  - Stimulus: rst pulsed for one cycle at byte 9.
  - Required: the next cycle shows Grant=00, DataReady=0, TimeoutCnt=0; the next request restarts at byte 0, and arbitration starts with c0=0.
